// File: rtl/asic_rmr2_ctrl.sv
// asic_rmr2_ctrl: resynchronises and glitch-filters gate-array writes, commits one per strobe,
// and decodes unlocked RMR2 writes into lower-ROM bank/location and ASIC page enable.
module asic_rmr2_ctrl #(
   parameter int MIN_LOW = 2
) (
   input  logic       clk,
   input  logic       reset_b,
   input  logic       ioreq_b,
   input  logic       wr_b,
   input  logic       io_cs,
   input  logic [7:0] data,
   input  logic       enf,
   input  logic       mreq_b,
   input  logic [1:0] addr,
   output logic [2:0] lrom_bank,
   output logic [1:0] lrom_loc,
   output logic       asic_page_en,
   output logic       rmr2_upd,
   output logic       gawr,
   output logic       asic_sel
);
   typedef enum logic [1:0] {IDLE, QUAL, DONE} state_t;
   state_t     st;
   logic [3:0] cnt;
   logic       s1, s2, e1, enf_s, commit, accept;
   logic [7:0] d_q;
   assign commit = s2 & ((st == IDLE && MIN_LOW == 1) || (st == QUAL && cnt == 4'(MIN_LOW - 1)));
   assign accept = commit & enf_s & (d_q[7:5] == 3'b101);
   assign asic_sel = asic_page_en & !mreq_b & (addr == 2'b01);
   always_ff @(posedge clk or negedge reset_b)
      if (!reset_b) begin
         st           <= IDLE;
         cnt          <= '0;
         s1           <= 1'b0;
         s2           <= 1'b0;
         e1           <= 1'b0;
         enf_s        <= 1'b0;
         d_q          <= '0;
         gawr         <= 1'b0;
         rmr2_upd     <= 1'b0;
         lrom_bank    <= '0;
         lrom_loc     <= '0;
         asic_page_en <= 1'b0;
      end else begin
         s1       <= !ioreq_b & !wr_b & io_cs;
         s2       <= s1;
         e1       <= enf;
         enf_s    <= e1;
         d_q      <= data;
         gawr     <= commit;
         rmr2_upd <= accept;
         if (accept) begin
            lrom_loc     <= d_q[4:3];
            lrom_bank    <= d_q[2:0];
            asic_page_en <= (d_q[4:3] == 2'b11);
         end
         case (st)
            IDLE: if (s2) begin
               st  <= commit ? DONE : QUAL;
               cnt <= 4'd1;
            end
            QUAL: begin
               st  <= !s2 ? IDLE : commit ? DONE : QUAL;
               cnt <= cnt + 4'd1;
            end
            DONE: if (!s2) st <= IDLE;
            default: st <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_asic_rmr2_ctrl.sv
// tb_asic_rmr2_ctrl: table-driven and randomized write checks on two instances (MIN_LOW=2 and 1)
// against a write-level model of the RMR2 register.
module tb_asic_rmr2_ctrl;
   logic       clk, reset_b, ioreq_b, wr_b, io_cs, enf, mreq_b;
   logic [7:0] data;
   logic [1:0] addr;
   logic [2:0] bank2, bank1;
   logic [1:0] loc2, loc1;
   logic       pg2, pg1, upd2, upd1, gawr2, gawr1, sel2, sel1;
   int         n_chk = 0, n_fail = 0;
   logic [7:0] r2 = 8'h00, r1 = 8'h00;

   asic_rmr2_ctrl #(.MIN_LOW(2)) dut2 (
      .clk(clk), .reset_b(reset_b), .ioreq_b(ioreq_b), .wr_b(wr_b), .io_cs(io_cs), .data(data),
      .enf(enf), .mreq_b(mreq_b), .addr(addr), .lrom_bank(bank2), .lrom_loc(loc2),
      .asic_page_en(pg2), .rmr2_upd(upd2), .gawr(gawr2), .asic_sel(sel2));
   asic_rmr2_ctrl #(.MIN_LOW(1)) dut1 (
      .clk(clk), .reset_b(reset_b), .ioreq_b(ioreq_b), .wr_b(wr_b), .io_cs(io_cs), .data(data),
      .enf(enf), .mreq_b(mreq_b), .addr(addr), .lrom_bank(bank1), .lrom_loc(loc1),
      .asic_page_en(pg1), .rmr2_upd(upd1), .gawr(gawr1), .asic_sel(sel1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       e;
      logic [7:0] d;
      int         len, pre, tail;
      logic [2:0] bank;
      logic [1:0] loc;
      logic       pg;
   } vec_t;
   vec_t tbl[7];

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_all_zero();
      chk("rst_bank2", int'(bank2), 0); chk("rst_loc2", int'(loc2), 0); chk("rst_pg2", int'(pg2), 0);
      chk("rst_upd2", int'(upd2), 0);   chk("rst_gawr2", int'(gawr2), 0); chk("rst_sel2", int'(sel2), 0);
      chk("rst_bank1", int'(bank1), 0); chk("rst_loc1", int'(loc1), 0); chk("rst_pg1", int'(pg1), 0);
      chk("rst_upd1", int'(upd1), 0);   chk("rst_gawr1", int'(gawr1), 0); chk("rst_sel1", int'(sel1), 0);
   endtask

   // A strobe sampled on edges 1..len is accepted when len reaches MIN_LOW; the pulse
   // then appears after edge MIN_LOW+2 counted from the first sampling edge.
   task automatic wr(input logic e, input logic [7:0] d, input int len, input int pre,
                     input int tail, input logic cs);
      logic acc;
      enf = e;
      repeat (pre) @(negedge clk);
      data = d; ioreq_b = 1'b0; wr_b = 1'b0; io_cs = cs;
      acc = e && d[7:5] == 3'b101;
      for (int k = 1; k <= len + tail; k++) begin
         @(posedge clk); @(negedge clk);
         chk("gawr2", int'(gawr2), int'(cs && len >= 2 && k == 4));
         chk("upd2", int'(upd2), int'(cs && len >= 2 && k == 4 && acc));
         chk("gawr1", int'(gawr1), int'(cs && len >= 1 && k == 3));
         chk("upd1", int'(upd1), int'(cs && len >= 1 && k == 3 && acc));
         if (k == len) begin ioreq_b = 1'b1; wr_b = 1'b1; io_cs = 1'b0; end
      end
      if (cs && len >= 2 && acc) r2 = d;
      if (cs && len >= 1 && acc) r1 = d;
      chk("bank2", int'(bank2), int'(r2[2:0])); chk("loc2", int'(loc2), int'(r2[4:3]));
      chk("pg2", int'(pg2), int'(r2[4:3] == 2'b11));
      chk("bank1", int'(bank1), int'(r1[2:0])); chk("loc1", int'(loc1), int'(r1[4:3]));
      chk("pg1", int'(pg1), int'(r1[4:3] == 2'b11));
      mreq_b = 1'($urandom_range(0, 1)); addr = 2'($urandom_range(0, 3));
      #1;
      chk("sel2", int'(sel2), int'(r2[4:3] == 2'b11 && !mreq_b && addr == 2'b01));
      chk("sel1", int'(sel1), int'(r1[4:3] == 2'b11 && !mreq_b && addr == 2'b01));
   endtask

   initial begin
      tbl[0] = '{1'b1, 8'hB9, 6, 3, 6, 3'd1, 2'd3, 1'b1};
      tbl[1] = '{1'b0, 8'hA2, 6, 3, 6, 3'd1, 2'd3, 1'b1};
      tbl[2] = '{1'b1, 8'hA2, 6, 3, 6, 3'd2, 2'd0, 1'b0};
      tbl[3] = '{1'b1, 8'h8C, 6, 3, 6, 3'd2, 2'd0, 1'b0};
      tbl[4] = '{1'b1, 8'hB1, 1, 3, 6, 3'd2, 2'd0, 1'b0};
      tbl[5] = '{1'b1, 8'hB1, 40, 3, 1, 3'd1, 2'd2, 1'b0};
      tbl[6] = '{1'b1, 8'hAB, 6, 0, 6, 3'd3, 2'd1, 1'b0};
      reset_b = 1'b0; ioreq_b = 1'b1; wr_b = 1'b1; io_cs = 1'b0; data = 8'h00;
      enf = 1'b0; mreq_b = 1'b1; addr = 2'b00;
      repeat (3) @(negedge clk);
      chk_all_zero();
      reset_b = 1'b1; mreq_b = 1'b0; addr = 2'b01;
      @(negedge clk); #1;
      chk("sel2_locked", int'(sel2), 0);
      chk("sel1_locked", int'(sel1), 0);
      @(negedge clk);
      for (int i = 0; i < 7; i++) begin
         wr(tbl[i].e, tbl[i].d, tbl[i].len, tbl[i].pre, tbl[i].tail, 1'b1);
         chk("tbl_bank", int'(bank2), int'(tbl[i].bank));
         chk("tbl_loc", int'(loc2), int'(tbl[i].loc));
         chk("tbl_pg", int'(pg2), int'(tbl[i].pg));
      end
      // Reset asserted while the MIN_LOW=2 instance is qualifying a strobe.
      @(negedge clk);
      enf = 1'b1;
      repeat (3) @(negedge clk);
      data = 8'hB9; ioreq_b = 1'b0; wr_b = 1'b0; io_cs = 1'b1;
      repeat (3) @(negedge clk);
      reset_b = 1'b0;
      #1;
      chk_all_zero();
      ioreq_b = 1'b1; wr_b = 1'b1; io_cs = 1'b0;
      repeat (2) @(negedge clk);
      reset_b = 1'b1;
      r2 = 8'h00; r1 = 8'h00;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("rst_nopulse2", int'(gawr2), 0);
         chk("rst_nopulse1", int'(gawr1), 0);
      end
      for (int i = 0; i < 40; i++) begin
         logic [7:0] d;
         d = 8'($urandom);
         if ($urandom_range(0, 1) == 1) d[7:5] = 3'b101;
         wr($urandom_range(0, 3) != 0, d,
            ($urandom_range(0, 4) == 0) ? 20 : int'($urandom_range(1, 5)),
            3, 5, $urandom_range(0, 9) != 0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
